// File: rtl/pipe_add_pkg.sv
// Shared constants and the signed-overflow rule for the pipelined adder/subtractor.
package pipe_add_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Overflow when both addends share a sign and the result sign differs.
  function automatic logic ovf_calc(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/add_slice.sv
// One combinational carry-chain slice of the pipelined adder.
module add_slice #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);

  assign {co, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};

endmodule

// File: rtl/pipe_add_sub.sv
// N-bit add/subtract split into STAGES registered carry slices with a global-stall handshake.
module pipe_add_sub
  import pipe_add_pkg::*;
#(
  parameter int N      = 8,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf,
  output logic         zero
);

  localparam int CHUNK = N / STAGES;

  if (N < 2 || STAGES < 1 || STAGES > N || (N % STAGES) != 0) begin : g_bad_cfg
    $error("pipe_add_sub: need N >= 2, 1 <= STAGES <= N and N %% STAGES == 0");
  end

  logic              advance;
  logic [STAGES-1:0] vld_q;
  logic [STAGES:0]   vld_pipe;

  logic [N-1:0] sum_d, sum_q;
  logic         cout_d, cout_q, ovf_d, ovf_q, zero_d, zero_q;

  assign advance   = !vld_pipe[STAGES] || out_ready;
  assign in_ready  = advance && !rst;
  assign vld_pipe  = {vld_q, in_valid};
  assign out_valid = vld_pipe[STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          vld_q <= '0;
    else if (advance) vld_q <= vld_pipe[STAGES-1:0];
  end

  // Stage k consumes the operand bits from LO upward; bits below LO are already summed.
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int LO = k * CHUNK;

    logic [N-1:LO]         ua, ub;
    logic                  ci;
    logic [CHUNK-1:0]      ss;
    logic                  co;
    logic [LO+CHUNK-1:0]   s_new;

    if (k == 0) begin : g_in
      assign ua    = a;
      assign ub    = (op == OP_SUB) ? ~b : b;
      assign ci    = (op == OP_SUB) ? ~cin : cin;
      assign s_new = ss;
    end else begin : g_in
      assign ua    = g_st[k-1].g_reg.a_q;
      assign ub    = g_st[k-1].g_reg.b_q;
      assign ci    = g_st[k-1].g_reg.c_q;
      assign s_new = {ss, g_st[k-1].g_reg.s_q};
    end

    add_slice #(.W(CHUNK)) u_slice (
      .a  (ua[LO +: CHUNK]),
      .b  (ub[LO +: CHUNK]),
      .ci (ci),
      .s  (ss),
      .co (co)
    );

    if (k < STAGES - 1) begin : g_reg
      logic [N-1:LO+CHUNK] a_q, b_q;
      logic [LO+CHUNK-1:0] s_q;
      logic                c_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
          s_q <= '0;
          c_q <= 1'b0;
        end else if (advance) begin
          a_q <= ua[N-1:LO+CHUNK];
          b_q <= ub[N-1:LO+CHUNK];
          s_q <= s_new;
          c_q <= co;
        end
      end
    end else begin : g_out
      assign sum_d  = s_new;
      assign cout_d = co;
      assign ovf_d  = ovf_calc(ua[N-1], ub[N-1], ss[CHUNK-1]);
    end
  end

  assign zero_d = (sum_d == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (advance) begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;

endmodule

// File: tb/tb_pipe_add_sub.sv
// Randomized and directed checks of pipe_add_sub in three configurations against an arithmetic model.
module tb_pipe_add_sub;
  import pipe_add_pkg::*;

  logic clk;
  int   n_chk  = 0;
  int   n_pass = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_cfg
    localparam int CN = (g == 1) ? 16 : 8;
    localparam int CS = (g == 0) ? 2 : ((g == 1) ? 4 : 1);

    logic          rst, in_valid, in_ready, cin, op, out_valid, out_ready, cout, ovf, zero;
    logic [CN-1:0] a, b, sum;

    pipe_add_sub #(.N(CN), .STAGES(CS)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf),
      .zero      (zero)
    );

    logic [CN+2:0] exp_q[$];
    logic [CN+2:0] prev_out;
    bit            prev_stall = 0;
    bit            done = 0;
    int            mode = 0;
    int            scyc = 0;
    int            n_out = 0;

    // Reference: plain wide arithmetic, packed as {cout, ovf, zero, sum}.
    function automatic logic [CN+2:0] ref_res(input logic [CN-1:0] x, input logic [CN-1:0] y,
                                               input logic ci, input logic o);
      logic [CN:0]   w;
      logic [CN-1:0] s;
      logic          co, be_msb;
      if (o == OP_ADD) begin
        w      = {1'b0, x} + {1'b0, y} + {{CN{1'b0}}, ci};
        co     = w[CN];
        be_msb = y[CN-1];
      end else begin
        w      = {1'b0, x} - {1'b0, y} - {{CN{1'b0}}, ci};
        co     = !w[CN];
        be_msb = !y[CN-1];
      end
      s = w[CN-1:0];
      return {co, ovf_calc(x[CN-1], be_msb, s[CN-1]), s == '0, s};
    endfunction

    always @(negedge clk) begin
      if (rst) begin
        exp_q.delete();
        prev_stall = 0;
      end else begin
        if (prev_stall) begin
          chk($sformatf("c%0d hold_valid", g), 64'(out_valid), 64'd1);
          chk($sformatf("c%0d hold_data", g), 64'({cout, ovf, zero, sum}), 64'(prev_out));
        end
        chk($sformatf("c%0d in_ready", g), 64'(in_ready), 64'(!out_valid || out_ready));
        if (out_valid && out_ready) begin
          n_out++;
          if (exp_q.size() == 0) chk($sformatf("c%0d spurious_out", g), 64'(out_valid), 64'd0);
          else chk($sformatf("c%0d result", g), 64'({cout, ovf, zero, sum}), 64'(exp_q.pop_front()));
        end
        if (in_valid && in_ready) exp_q.push_back(ref_res(a, b, cin, op));
        prev_stall = out_valid && !out_ready;
        prev_out   = {cout, ovf, zero, sum};
      end
    end

    task automatic tick();
      @(posedge clk);
      #1;
      scyc++;
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = !(scyc >= 3 && scyc <= 5);
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    endtask

    task automatic send(input logic [CN-1:0] x, input logic [CN-1:0] y, input logic ci, input logic o);
      bit ok;
      int n = 0;
      in_valid = 1'b1; a = x; b = y; cin = ci; op = o;
      do begin
        @(negedge clk);
        ok = in_ready;
        tick();
        n++;
      end while (!ok && n < 200);
      if (!ok) chk($sformatf("c%0d send_timeout", g), 64'(in_ready), 64'd1);
      in_valid = 1'b0;
    endtask

    task automatic single(input string tag, input logic [CN-1:0] x, input logic [CN-1:0] y,
                          input logic ci, input logic o, input logic [CN-1:0] es,
                          input logic ec, input logic ev, input logic ez);
      int lat;
      mode = 0;
      send(x, y, ci, o);
      lat = 1;
      while (!out_valid && lat < 20) begin
        tick();
        lat++;
      end
      chk($sformatf("c%0d %s latency", g, tag), 64'(lat), 64'(CS));
      chk($sformatf("c%0d %s sum", g, tag), 64'(sum), 64'(es));
      chk($sformatf("c%0d %s flags", g, tag), 64'({cout, ovf, zero}), 64'({ec, ev, ez}));
      tick();
    endtask

    task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < 500) begin
        tick();
        n++;
      end
      chk($sformatf("c%0d drained", g), 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
      logic [CN-1:0] all1, maxp, minn, neg10;
      int            n0;
      all1  = '1;
      maxp  = {1'b0, {(CN-1){1'b1}}};
      minn  = {1'b1, {(CN-1){1'b0}}};
      neg10 = '0;
      neg10 = neg10 - CN'(10);

      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; op = OP_ADD; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk($sformatf("c%0d rst_state", g), 64'({out_valid, cout, ovf, zero, sum}), 64'd0);
      rst = 1'b0;
      #1;
      chk($sformatf("c%0d rst_in_ready", g), 64'(in_ready), 64'd1);

      single("add",      CN'(10), CN'(20), 1'b0, OP_ADD, CN'(30), 1'b0, 1'b0, 1'b0);
      single("add_wrap", all1,    CN'(1),  1'b0, OP_ADD, '0,      1'b1, 1'b0, 1'b1);
      single("add_ovf",  maxp,    CN'(1),  1'b0, OP_ADD, minn,    1'b0, 1'b1, 1'b0);
      single("add_cin",  all1,    CN'(0),  1'b1, OP_ADD, '0,      1'b1, 1'b0, 1'b1);
      single("sub",      CN'(10), CN'(20), 1'b0, OP_SUB, neg10,   1'b0, 1'b0, 1'b0);
      single("sub_ovf",  minn,    CN'(1),  1'b0, OP_SUB, maxp,    1'b1, 1'b1, 1'b0);
      single("sub_bin",  CN'(5),  CN'(3),  1'b1, OP_SUB, CN'(1),  1'b1, 1'b0, 1'b0);

      // Stream of six beats with a downstream stall window.
      n0 = n_out;
      scyc = 0;
      mode = 1;
      for (int i = 1; i <= 6; i++) send(CN'(10), CN'(10 * i), 1'b0, OP_ADD);
      drain();
      chk($sformatf("c%0d stream_count", g), 64'(n_out - n0), 64'd6);

      // Reset with beats in flight.
      mode = 0;
      send(CN'(1), CN'(1), 1'b0, OP_ADD);
      send(CN'(2), CN'(2), 1'b0, OP_ADD);
      rst = 1'b1;
      #1;
      chk($sformatf("c%0d rst_async_valid", g), 64'(out_valid), 64'd0);
      repeat (2) tick();
      rst = 1'b0;
      for (int i = 0; i < CS + 2; i++) begin
        tick();
        chk($sformatf("c%0d no_stale", g), 64'(out_valid), 64'd0);
      end
      single("post_rst", CN'(1), CN'(2), 1'b0, OP_ADD, CN'(3), 1'b0, 1'b0, 1'b0);

      // Random beats with random backpressure.
      n0 = n_out;
      mode = 2;
      for (int i = 0; i < 1000; i++)
        send(CN'($urandom), CN'($urandom), 1'($urandom), 1'($urandom));
      drain();
      chk($sformatf("c%0d random_count", g), 64'(n_out - n0), 64'd1000);
      mode = 0;
      done = 1;
    end
  end

  initial begin
    int n = 0;
    while (!(g_cfg[0].done && g_cfg[1].done && g_cfg[2].done) && n < 40000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 40000)
      chk("timeout", 64'({g_cfg[0].done, g_cfg[1].done, g_cfg[2].done}), 64'b111);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
